// File: rtl/alu_flag_unit.sv
// alu_flag_unit: 6502-style 8-bit ALU with T, P and carry-temp state.
// Decimal adjust on ADD/SUB is built only when ALU_BCD_EN is defined.
module alu_flag_unit (
  input  logic       ph2,
  input  logic       reset,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  input  logic [3:0] alu_op,
  input  logic       carry_sel,
  input  logic       c_temp_en,
  input  logic       t_in_en,
  input  logic       t_out_en,
  input  logic [7:0] p_in_en,
  input  logic       p_sel,
  input  logic       p_out_en,
  output logic [7:0] r,
  output logic [7:0] r_q,
  output logic [7:0] f_q,
  output logic [7:0] t_q,
  output logic [7:0] p_q,
  output logic [7:0] bus_out,
  output logic       bus_oe
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_ASL   = 4'd5;
  localparam logic [3:0] OP_ROL   = 4'd6;
  localparam logic [3:0] OP_LSR   = 4'd7;
  localparam logic [3:0] OP_ROR   = 4'd8;
  localparam logic [3:0] OP_INC   = 4'd9;
  localparam logic [3:0] OP_DEC   = 4'd10;
  localparam logic [3:0] OP_PASSB = 4'd11;

  logic       c_temp;
  logic       cin;
  logic       dec;
  logic [7:0] flags;
  logic       c_out;
  logic       v_out;

  logic is_add;
  logic is_sub;
  logic is_and;
  logic is_or;
  logic is_xor;
  logic is_asl;
  logic is_rol;
  logic is_lsr;
  logic is_ror;
  logic is_inc;
  logic is_dec;
  logic is_passb;
  logic is_passa;

  assign cin = carry_sel ? c_temp : p_q[0];

`ifdef ALU_BCD_EN
  assign dec = p_q[4];
`else
  assign dec = 1'b0;
`endif

  always_comb begin
    is_add   = (alu_op == OP_ADD);
    is_sub   = (alu_op == OP_SUB);
    is_and   = (alu_op == OP_AND);
    is_or    = (alu_op == OP_OR);
    is_xor   = (alu_op == OP_XOR);
    is_asl   = (alu_op == OP_ASL);
    is_rol   = (alu_op == OP_ROL);
    is_lsr   = (alu_op == OP_LSR);
    is_ror   = (alu_op == OP_ROR);
    is_inc   = (alu_op == OP_INC);
    is_dec   = (alu_op == OP_DEC);
    is_passb = (alu_op == OP_PASSB);
    is_passa = (alu_op[3:2] == 2'b11);
  end

  // SUB shares the adder by feeding ~B; carry out means no borrow
  logic [7:0] b_eff;
  logic [8:0] sum;
  logic       v_bin;

  assign b_eff = is_sub ? ~b_in : b_in;
  assign sum   = {1'b0, a_in} + {1'b0, b_eff} + {8'd0, cin};
  assign v_bin = (a_in[7] == b_eff[7]) && (sum[7] != a_in[7]);

`ifdef ALU_BCD_EN
  logic [4:0] lo_sum;
  logic       lo_gt9;
  logic [3:0] lo_add;
  logic [4:0] hi_sum;
  logic       hi_gt9;
  logic [3:0] hi_add;
  logic [7:0] dadd;
  logic       lo_borrow;
  logic       hi_borrow;
  logic [7:0] dsub_fix;
  logic [7:0] dsub;

  always_comb begin
    lo_sum = {1'b0, a_in[3:0]} + {1'b0, b_eff[3:0]} + {4'd0, cin};
    lo_gt9 = (lo_sum > 5'd9);
    lo_add = lo_sum[3:0] + (lo_gt9 ? 4'd6 : 4'd0);
    hi_sum = {1'b0, a_in[7:4]} + {1'b0, b_eff[7:4]} + {4'd0, lo_gt9};
    hi_gt9 = (hi_sum > 5'd9);
    hi_add = hi_sum[3:0] + (hi_gt9 ? 4'd6 : 4'd0);
    dadd   = {hi_add, lo_add};
  end

  // borrow out of a nibble shows up as a missing carry in the ~B form
  always_comb begin
    lo_borrow = ~lo_sum[4];
    hi_borrow = ~sum[8];
    dsub_fix  = {hi_borrow ? 4'h6 : 4'h0,
                 lo_borrow ? 4'h6 : 4'h0};
    dsub      = sum[7:0] - dsub_fix;
  end
`endif

  always_comb begin
    r     = a_in;
    c_out = cin;
    v_out = 1'b0;
    unique case (1'b1)
      is_add: begin
        r     = sum[7:0];
        c_out = sum[8];
        v_out = v_bin;
`ifdef ALU_BCD_EN
        if (dec) begin
          r     = dadd;
          c_out = hi_gt9;
        end
`endif
      end
      is_sub: begin
        r     = sum[7:0];
        c_out = sum[8];
        v_out = v_bin;
`ifdef ALU_BCD_EN
        if (dec) begin
          r = dsub;
        end
`endif
      end
      is_and:   r = a_in & b_in;
      is_or:    r = a_in | b_in;
      is_xor:   r = a_in ^ b_in;
      is_asl: begin
        r     = {a_in[6:0], 1'b0};
        c_out = a_in[7];
      end
      is_rol: begin
        r     = {a_in[6:0], cin};
        c_out = a_in[7];
      end
      is_lsr: begin
        r     = {1'b0, a_in[7:1]};
        c_out = a_in[0];
      end
      is_ror: begin
        r     = {cin, a_in[7:1]};
        c_out = a_in[0];
      end
      is_inc:   r = a_in + 8'd1;
      is_dec:   r = a_in - 8'd1;
      is_passb: r = b_in;
      is_passa: r = a_in;
    endcase
  end

  logic dec_unused;
  assign dec_unused = dec;

  always_comb begin
    flags    = 8'h00;
    flags[7] = r[7];
    flags[6] = v_out;
    flags[1] = (r == 8'h00);
    flags[0] = c_out;
  end

  always_ff @(posedge ph2 or negedge reset) begin
    if (!reset) begin
      r_q <= 8'h00;
      f_q <= 8'h00;
    end else begin
      r_q <= r;
      f_q <= flags;
    end
  end

  always_ff @(posedge ph2 or negedge reset) begin
    if (!reset) begin
      t_q <= 8'h00;
    end else if (t_in_en) begin
      t_q <= r_q;
    end
  end

  logic [7:0] p_src;
  logic [7:0] p_next;

  assign p_src  = p_sel ? r_q : f_q;
  assign p_next = (p_in_en & p_src) | (~p_in_en & p_q);

  always_ff @(posedge ph2 or negedge reset) begin
    if (!reset) begin
      p_q <= 8'h00;
    end else begin
      p_q <= p_next;
    end
  end

  always_ff @(posedge ph2 or negedge reset) begin
    if (!reset) begin
      c_temp <= 1'b0;
    end else if (c_temp_en) begin
      c_temp <= f_q[0];
    end
  end

  always_comb begin
    bus_out = 8'h00;
    if (t_out_en) begin
      bus_out = t_q;
    end else if (p_out_en) begin
      bus_out = p_q;
    end
  end

  assign bus_oe = t_out_en | p_out_en;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Bench for alu_flag_unit: vector table, hand sequences, random vs model.
// Build with ALU_BCD_EN defined to exercise the decimal expectations.
module tb_alu_flag_unit;

  logic       ph2 = 1'b0;
  logic       reset;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic [3:0] alu_op;
  logic       carry_sel;
  logic       c_temp_en;
  logic       t_in_en;
  logic       t_out_en;
  logic [7:0] p_in_en;
  logic       p_sel;
  logic       p_out_en;
  logic [7:0] r;
  logic [7:0] r_q;
  logic [7:0] f_q;
  logic [7:0] t_q;
  logic [7:0] p_q;
  logic [7:0] bus_out;
  logic       bus_oe;

  alu_flag_unit dut (
    .ph2(ph2), .reset(reset), .a_in(a_in), .b_in(b_in),
    .alu_op(alu_op), .carry_sel(carry_sel),
    .c_temp_en(c_temp_en), .t_in_en(t_in_en),
    .t_out_en(t_out_en), .p_in_en(p_in_en), .p_sel(p_sel),
    .p_out_en(p_out_en), .r(r), .r_q(r_q), .f_q(f_q),
    .t_q(t_q), .p_q(p_q), .bus_out(bus_out), .bus_oe(bus_oe)
  );

  always #5 ph2 = ~ph2;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int sx(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  // reference: returns {result, flags}
  function automatic logic [15:0] ref_alu(input int op, input int a,
      input int b, input int cin, input int dec);
    int res, c, v, s, lo, hi, lc;
    logic [7:0] r8;
    logic [7:0] f8;
    res = a; c = cin; v = 0;
    case (op)
      0: begin
        s = sx(a) + sx(b) + cin;
        v = (s > 127 || s < -128) ? 1 : 0;
        res = a + b + cin;
        c = (res > 255) ? 1 : 0;
        if (dec != 0) begin
          lo = a % 16 + b % 16 + cin;
          lc = (lo > 9) ? 1 : 0;
          if (lc != 0) lo += 6;
          hi = a / 16 + b / 16 + lc;
          c = (hi > 9) ? 1 : 0;
          if (c != 0) hi += 6;
          res = (hi % 16) * 16 + lo % 16;
        end
      end
      1: begin
        s = sx(a) - sx(b) - (1 - cin);
        v = (s > 127 || s < -128) ? 1 : 0;
        res = a - b - (1 - cin);
        c = (res >= 0) ? 1 : 0;
        if (dec != 0) begin
          lo = a % 16 - b % 16 - (1 - cin);
          if (lo < 0) res -= 6;
          if (c == 0) res -= 96;
        end
      end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: begin res = a * 2; c = a / 128; end
      6: begin res = a * 2 + cin; c = a / 128; end
      7: begin res = a / 2; c = a % 2; end
      8: begin res = a / 2 + cin * 128; c = a % 2; end
      9: res = a + 1;
      10: res = a + 255;
      11: res = b;
      default: res = a;
    endcase
    r8 = res[7:0];
    f8 = 8'h00;
    f8[7] = r8[7];
    f8[6] = (v != 0);
    f8[1] = (r8 == 8'h00);
    f8[0] = (c != 0);
    return {r8, f8};
  endfunction

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
    logic [7:0] er;
    logic [7:0] ef;
  } vec_t;

  localparam int NV = 18;
  vec_t tv [NV];

  task automatic tick();
    @(posedge ph2);
    #1;
  endtask

  task automatic set_p(input logic [7:0] v);
    alu_op = 4'd11;
    b_in = v;
    p_in_en = 8'h00;
    tick();
    p_in_en = 8'hFF;
    p_sel = 1'b1;
    tick();
    p_in_en = 8'h00;
    p_sel = 1'b0;
  endtask

  logic [7:0] mp, mrq, mfq, mt, er, ef, eb;
  logic       mc;
  int         cin_m, dec_m;

  initial begin
    tv[0]  = '{4'd0,  8'h50, 8'h50, 8'h00, 8'hA0, 8'hC0};
    tv[1]  = '{4'd1,  8'h00, 8'h01, 8'h01, 8'hFF, 8'h80};
    tv[2]  = '{4'd1,  8'h05, 8'h05, 8'h01, 8'h00, 8'h03};
    tv[3]  = '{4'd8,  8'h01, 8'h00, 8'h01, 8'h80, 8'h81};
    tv[4]  = '{4'd5,  8'h80, 8'h00, 8'h00, 8'h00, 8'h03};
`ifdef ALU_BCD_EN
    tv[5]  = '{4'd0,  8'h19, 8'h28, 8'h10, 8'h47, 8'h00};
    tv[6]  = '{4'd0,  8'h99, 8'h01, 8'h10, 8'h00, 8'h03};
    tv[7]  = '{4'd1,  8'h10, 8'h01, 8'h11, 8'h09, 8'h01};
`else
    tv[5]  = '{4'd0,  8'h19, 8'h28, 8'h10, 8'h41, 8'h00};
    tv[6]  = '{4'd0,  8'h99, 8'h01, 8'h10, 8'h9A, 8'h80};
    tv[7]  = '{4'd1,  8'h10, 8'h01, 8'h11, 8'h0F, 8'h01};
`endif
    tv[8]  = '{4'd2,  8'hF0, 8'h3C, 8'h01, 8'h30, 8'h01};
    tv[9]  = '{4'd3,  8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
    tv[10] = '{4'd4,  8'hFF, 8'h0F, 8'h00, 8'hF0, 8'h80};
    tv[11] = '{4'd6,  8'h80, 8'h00, 8'h01, 8'h01, 8'h01};
    tv[12] = '{4'd7,  8'h01, 8'h00, 8'h00, 8'h00, 8'h03};
    tv[13] = '{4'd9,  8'hFF, 8'h00, 8'h00, 8'h00, 8'h02};
    tv[14] = '{4'd10, 8'h00, 8'h00, 8'h01, 8'hFF, 8'h81};
    tv[15] = '{4'd11, 8'h00, 8'h7F, 8'h00, 8'h7F, 8'h00};
    tv[16] = '{4'd13, 8'h80, 8'h11, 8'h00, 8'h80, 8'h80};
    tv[17] = '{4'd0,  8'h7F, 8'h00, 8'h01, 8'h80, 8'hC0};

    reset = 1'b0;
    a_in = 8'h00; b_in = 8'h00; alu_op = 4'd0;
    carry_sel = 1'b0; c_temp_en = 1'b0; t_in_en = 1'b0;
    t_out_en = 1'b0; p_in_en = 8'h00; p_sel = 1'b0;
    p_out_en = 1'b0;

    #12;
    chk("rst_rq", r_q, 8'h00);
    chk("rst_fq", f_q, 8'h00);
    chk("rst_tq", t_q, 8'h00);
    chk("rst_pq", p_q, 8'h00);
    chk("rst_bus", {bus_oe, bus_out}, 9'h000);
    reset = 1'b1;
    tick();

    // flags 0x81, then partial P loads and carry-temp
    alu_op = 4'd0; a_in = 8'hFF; b_in = 8'hFF;
    tick();
    chk("seq_fq", f_q, 8'h81);
    chk("seq_rq", r_q, 8'hFE);
    alu_op = 4'd0; a_in = 8'h00; b_in = 8'h00; carry_sel = 1'b1;
    #1;
    chk("ctemp_pre", r, 8'h00);
    alu_op = 4'd11; b_in = 8'hFF; carry_sel = 1'b0;
    c_temp_en = 1'b1; p_in_en = 8'h01; p_sel = 1'b0;
    tick();
    chk("p_load_f", p_q, 8'h01);
    c_temp_en = 1'b0;
    p_in_en = 8'h10; p_sel = 1'b1;
    tick();
    chk("p_load_r", p_q, 8'h11);
    p_in_en = 8'h00; p_sel = 1'b0;
    alu_op = 4'd0; a_in = 8'h00; b_in = 8'h00; carry_sel = 1'b1;
    #1;
    chk("ctemp_cin", r, 8'h01);
    carry_sel = 1'b0;

    alu_op = 4'd11; b_in = 8'h5A;
    tick();
    t_in_en = 1'b1;
    tick();
    t_in_en = 1'b0;
    chk("t_load", t_q, 8'h5A);
    t_out_en = 1'b1; p_out_en = 1'b1;
    #1;
    chk("bus_both", {bus_oe, bus_out}, 9'h15A);
    t_out_en = 1'b0;
    #1;
    chk("bus_p", {bus_oe, bus_out}, 9'h111);
    p_out_en = 1'b0;
    #1;
    chk("bus_none", {bus_oe, bus_out}, 9'h000);
    b_in = 8'h33;
    tick();
    t_in_en = 1'b1; t_out_en = 1'b1;
    #1;
    chk("bus_old", bus_out, 8'h5A);
    tick();
    t_in_en = 1'b0;
    chk("bus_new", bus_out, 8'h33);

    alu_op = 4'd0; a_in = 8'h01; b_in = 8'h02; carry_sel = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_tq", t_q, 8'h00);
    chk("mid_pq", p_q, 8'h00);
    chk("mid_rq", r_q, 8'h00);
    chk("mid_fq", f_q, 8'h00);
    chk("mid_r", r, 8'h03);
    chk("mid_bus", {bus_oe, bus_out}, 9'h100);
    reset = 1'b1;
    t_out_en = 1'b0; carry_sel = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) begin
      set_p(tv[i].p);
      alu_op = tv[i].op; a_in = tv[i].a; b_in = tv[i].b;
      #1;
      chk($sformatf("vec%0d_r", i), r, tv[i].er);
      tick();
      chk($sformatf("vec%0d_rq", i), r_q, tv[i].er);
      chk($sformatf("vec%0d_fq", i), f_q, tv[i].ef);
    end

    reset = 1'b0;
    #2;
    reset = 1'b1;
    mp = 8'h00; mrq = 8'h00; mfq = 8'h00; mt = 8'h00; mc = 1'b0;

    repeat (400) begin
      a_in = 8'($urandom);
      b_in = 8'($urandom);
      alu_op = 4'($urandom);
      carry_sel = 1'($urandom);
      c_temp_en = 1'($urandom);
      t_in_en = 1'($urandom);
      t_out_en = 1'($urandom);
      p_out_en = 1'($urandom);
      p_sel = 1'($urandom);
      p_in_en = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      @(negedge ph2);
      cin_m = carry_sel ? int'(mc) : int'(mp[0]);
`ifdef ALU_BCD_EN
      dec_m = int'(mp[4]);
`else
      dec_m = 0;
`endif
      {er, ef} = ref_alu(int'(alu_op), int'(a_in), int'(b_in),
                         cin_m, dec_m);
      eb = t_out_en ? mt : (p_out_en ? mp : 8'h00);
      chk("rnd_r", r, er);
      chk("rnd_rq", r_q, mrq);
      chk("rnd_fq", f_q, mfq);
      chk("rnd_tq", t_q, mt);
      chk("rnd_pq", p_q, mp);
      chk("rnd_bus", {bus_oe, bus_out},
          {t_out_en | p_out_en, eb});
      @(posedge ph2);
      if (t_in_en) mt = mrq;
      for (int k = 0; k < 8; k++) begin
        if (p_in_en[k]) mp[k] = p_sel ? mrq[k] : mfq[k];
      end
      if (c_temp_en) mc = mfq[0];
      mrq = er;
      mfq = ef;
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
